// File: rtl/izh_pkg.sv
// Shared definitions for the Izhikevich neuron scheduler: FSM state encoding
// and the model constants expressed in Q8 fixed point (value * 256, truncated).
package izh_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CALC,
    WRITE,
    DONE
  } izh_state_e;

  // Model coefficients in Q8.
  localparam int A       = 5;       // 0.02
  localparam int B       = 51;      // 0.2
  localparam int C       = -16640;  // -65.0, post-spike reset potential
  localparam int D       = 2048;    // 8.0, post-spike recovery bump
  localparam int V_PEAK  = 7680;    // 30.0, spike threshold
  localparam int K004    = 10;      // 0.04
  localparam int K5      = 1280;    // 5.0
  localparam int K140    = 35840;   // 140.0
  // Reset recovery value b*c taken as the exact -13.0 rather than B*C in Q8.
  localparam int W_RESET = -3328;

endpackage

// File: rtl/izh_update_dp.sv
// Combinational Izhikevich update datapath.
//   dv = (0.04*v*v + 5*v + 140 - w + i) * step
//   dw = (a*(b*v - w)) * step
// Every multiply keeps the full product, shifts right arithmetically by Q and
// truncates to N bits; every add wraps at N bits.
module izh_update_dp
  import izh_pkg::*;
#(
  parameter int N = 20,
  parameter int Q = 8
) (
  input  logic signed [N-1:0] v,
  input  logic signed [N-1:0] w,
  input  logic signed [N-1:0] i,
  input  logic signed [N-1:0] step,
  output logic signed [N-1:0] dv,
  output logic signed [N-1:0] dw
);

  localparam logic signed [N-1:0] K004_N = N'(K004);
  localparam logic signed [N-1:0] K5_N   = N'(K5);
  localparam logic signed [N-1:0] K140_N = N'(K140);
  localparam logic signed [N-1:0] A_N    = N'(A);
  localparam logic signed [N-1:0] B_N    = N'(B);

  function automatic logic signed [N-1:0] qmul(input logic signed [N-1:0] x,
                                               input logic signed [N-1:0] y);
    logic signed [2*N-1:0] p;
    p = (2*N)'(x) * (2*N)'(y);
    p = p >>> Q;
    return p[N-1:0];
  endfunction

  logic signed [N-1:0] k_v;     // 0.04*v
  logic signed [N-1:0] k_vv;    // (0.04*v)*v, scaled first so v*v cannot wrap
  logic signed [N-1:0] lin_v;   // 5*v
  logic signed [N-1:0] rate_v;  // bracketed dv term before the step multiply
  logic signed [N-1:0] b_v;     // b*v
  logic signed [N-1:0] rate_w;  // a*(b*v - w)

  assign k_v    = qmul(K004_N, v);
  assign k_vv   = qmul(k_v, v);
  assign lin_v  = qmul(K5_N, v);
  assign rate_v = k_vv + lin_v + K140_N - w + i;
  assign dv     = qmul(rate_v, step);

  assign b_v    = qmul(B_N, v);
  assign rate_w = qmul(A_N, b_v - w);
  assign dw     = qmul(rate_w, step);

endmodule

// File: rtl/izhikevich_scheduler.sv
// Time-multiplexed Izhikevich neuron scheduler: one update datapath visits
// every neuron in turn (LOAD, CALC, WRITE = 3 cycles each) per tick.
// Optional feature macro: SPIKE_COUNT_EN adds the spike_count output.
module izhikevich_scheduler
  import izh_pkg::*;
#(
  parameter int N           = 20,
  parameter int Q           = 8,
  parameter int NUM_NEURONS = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [N-1:0]                     step,
  output logic [$clog2(NUM_NEURONS)-1:0]   i_addr,
  input  logic [N-1:0]                     i_data,
  output logic                             busy,
  output logic                             done,
  output logic                             spike_valid,
  output logic [$clog2(NUM_NEURONS)-1:0]   spike_idx,
  input  logic [$clog2(NUM_NEURONS)-1:0]   rd_idx,
  output logic [N-1:0]                     rd_v,
  output logic [N-1:0]                     rd_w
`ifdef SPIKE_COUNT_EN
  ,
  output logic [$clog2(NUM_NEURONS+1)-1:0] spike_count
`endif
);

  localparam int IW = $clog2(NUM_NEURONS);
  localparam logic [IW-1:0]       LAST_IDX  = IW'(NUM_NEURONS - 1);
  localparam logic signed [N-1:0] C_N       = N'(C);
  localparam logic signed [N-1:0] D_N       = N'(D);
  localparam logic signed [N-1:0] V_PEAK_N  = N'(V_PEAK);
  localparam logic signed [N-1:0] W_RESET_N = N'(W_RESET);

  izh_state_e state_q, state_d;
  logic [IW-1:0]       idx_q;
  logic signed [N-1:0] v_q, w_q, i_q, step_q;
  logic signed [N-1:0] dv_q, dw_q;
  logic signed [N-1:0] dv_d, dw_d;
  logic signed [N-1:0] v_mem [NUM_NEURONS];
  logic signed [N-1:0] w_mem [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] wr_sel;
  logic signed [N-1:0] v_sum, w_sum, v_wr, w_wr;
  logic                fire;

  izh_update_dp #(.N(N), .Q(Q)) u_dp (
    .v    (v_q),
    .w    (w_q),
    .i    (i_q),
    .step (step_q),
    .dv   (dv_d),
    .dw   (dw_d)
  );

  // Write-back values: spiking neurons snap v to c and bump w by d.
  assign v_sum = v_q + dv_q;
  assign w_sum = w_q + dw_q;
  assign fire  = (v_sum >= V_PEAK_N);
  assign v_wr  = fire ? C_N : v_sum;
  assign w_wr  = fire ? (w_sum + D_N) : w_sum;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic; start outside IDLE is simply dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = CALC;
      CALC:    state_d = WRITE;
      WRITE:   state_d = (idx_q == LAST_IDX) ? DONE : LOAD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    busy        = (state_q != IDLE);
    done        = (state_q == DONE);
    i_addr      = (state_q == LOAD) ? idx_q : '0;
    spike_valid = (state_q == WRITE) && fire;
    spike_idx   = idx_q;
  end

  // Pipeline registers: neuron index, operand capture, update results.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q  <= '0;
      v_q    <= '0;
      w_q    <= '0;
      i_q    <= '0;
      step_q <= '0;
      dv_q   <= '0;
      dw_q   <= '0;
    end else begin
      case (state_q)
        IDLE:  if (start) step_q <= step;
        LOAD: begin
          v_q <= v_mem[idx_q];
          w_q <= w_mem[idx_q];
          i_q <= i_data;
        end
        CALC: begin
          dv_q <= dv_d;
          dw_q <= dw_d;
        end
        WRITE: if (idx_q != LAST_IDX) idx_q <= idx_q + IW'(1);
        DONE:  idx_q <= '0;
        default: ;
      endcase
    end
  end

  // One write strobe per neuron entry.
  for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_wr_sel
    assign wr_sel[gi] = (state_q == WRITE) && (idx_q == IW'(gi));
  end

  // Neuron state array: reset to rest, written only in WRITE.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_NEURONS; k++) begin
      if (reset) begin
        v_mem[k] <= C_N;
        w_mem[k] <= W_RESET_N;
      end else if (wr_sel[k]) begin
        v_mem[k] <= v_wr;
        w_mem[k] <= w_wr;
      end
    end
  end

  assign rd_v = v_mem[rd_idx];
  assign rd_w = w_mem[rd_idx];

`ifdef SPIKE_COUNT_EN
  localparam int CW = $clog2(NUM_NEURONS + 1);
  logic [CW-1:0] cnt_q;

  // Spikes seen in the current tick; holds after done until the next start.
  always_ff @(posedge clk) begin
    if (reset)                         cnt_q <= '0;
    else if (state_q == IDLE && start) cnt_q <= '0;
    else if (spike_valid)              cnt_q <= cnt_q + CW'(1);
  end

  assign spike_count = cnt_q;
`endif

endmodule

// File: tb/tb_izhikevich_scheduler.sv
// Scoreboard bench for izhikevich_scheduler (N=20, Q=8, NUM_NEURONS=16).
module tb_izhikevich_scheduler;

  localparam int NN     = 16;
  localparam int V_RST  = -65 * 256;   // -65.0 in Q8
  localparam int W_RST  = -13 * 256;   // -13.0 in Q8
  localparam int I_FIRE = 160 * 256;   // 160.0 in Q8

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [19:0] step = 20'h00100;
  logic [3:0]  i_addr;
  logic [19:0] i_data;
  logic        busy, done, spike_valid;
  logic [3:0]  spike_idx;
  logic [3:0]  rd_idx = 4'd0;
  logic [19:0] rd_v, rd_w;
`ifdef SPIKE_COUNT_EN
  logic [4:0]  spike_count;
`endif

  izhikevich_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .step        (step),
    .i_addr      (i_addr),
    .i_data      (i_data),
    .busy        (busy),
    .done        (done),
    .spike_valid (spike_valid),
    .spike_idx   (spike_idx),
    .rd_idx      (rd_idx),
    .rd_v        (rd_v),
    .rd_w        (rd_w)
`ifdef SPIKE_COUNT_EN
    ,
    .spike_count (spike_count)
`endif
  );

  typedef struct {
    int idx;
    int cyc;
  } spk_t;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   mv [NN];
  int   mw [NN];
  int   cur_i [NN];
  int   done_q [$];
  spk_t spike_q [$];
  int   spk_seen = 0;
  int   spk_pred = 0;
  int   mon_d;
  spk_t mon_s;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign i_data = cur_i[i_addr][19:0];

  function automatic int sx(input logic [19:0] x);
    return int'($signed(x));
  endfunction

  function automatic int wrap(input longint x);
    longint y;
    y = x & 64'h00000000000FFFFF;
    if (y >= 64'sd524288) y = y - 64'sd1048576;
    return int'(y);
  endfunction

  function automatic int qm(input int a, input int b);
    longint p;
    p = longint'(a) * longint'(b);
    return wrap(p >>> 8);
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  task automatic reset_model();
    for (int k = 0; k < NN; k++) begin
      mv[k] = V_RST;
      mw[k] = W_RST;
    end
  endtask

  // Reference tick: Q8 model over all neurons, queue expected events.
  task automatic predict(input int c0);
    int v, w, s, dv, dw, vn, wn;
    spk_pred = 0;
    for (int k = 0; k < NN; k++) begin
      v  = mv[k];
      w  = mw[k];
      s  = wrap(longint'(qm(qm(10, v), v)) + qm(1280, v) + 35840 - w + cur_i[k]);
      dv = qm(s, 256);
      dw = qm(qm(5, wrap(longint'(qm(51, v)) - w)), 256);
      vn = wrap(longint'(v) + dv);
      wn = wrap(longint'(w) + dw);
      if (vn >= 7680) begin
        mv[k] = V_RST;
        mw[k] = wrap(longint'(wn) + 2048);
        spike_q.push_back('{idx: k, cyc: c0 + 3 * k + 3});
        spk_pred++;
      end else begin
        mv[k] = vn;
        mw[k] = wn;
      end
    end
    done_q.push_back(c0 + 3 * NN + 1);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents done or a spike.
  always @(negedge clk) begin
    if (done) begin
      total++;
      if (done_q.size() == 0) begin
        bad++;
        $display("FAIL done_unexpected: got done at cycle %0d, required none", cyc);
      end else begin
        mon_d = done_q.pop_front();
        if (mon_d != cyc) begin
          bad++;
          $display("FAIL done_cycle: got %0d required %0d", cyc, mon_d);
        end
      end
    end
    if (spike_valid) begin
      spk_seen++;
      total++;
      if (spike_q.size() == 0) begin
        bad++;
        $display("FAIL spike_unexpected: got idx %0d at cycle %0d, required none", spike_idx, cyc);
      end else begin
        mon_s = spike_q.pop_front();
        if (mon_s.idx != int'(spike_idx) || mon_s.cyc != cyc) begin
          bad++;
          $display("FAIL spike_event: got idx %0d cyc %0d required idx %0d cyc %0d",
                   spike_idx, cyc, mon_s.idx, mon_s.cyc);
        end
      end
    end
  end

  task automatic check_all(input string tag);
    for (int k = 0; k < NN; k++) begin
      rd_idx = 4'(k);
      #1;
      chk($sformatf("%s_v%0d", tag, k), sx(rd_v), mv[k]);
      chk($sformatf("%s_w%0d", tag, k), sx(rd_w), mw[k]);
    end
  endtask

  // One full tick; ghost_at>0 pulses a second start that many cycles in.
  task automatic tick(input string tag, input int ghost_at);
    int c0;
    @(posedge clk); #1;
    c0 = cyc;
    start = 1'b1;
    spk_seen = 0;
    predict(c0);
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy_after_start"}, int'(busy), 1);
`ifdef SPIKE_COUNT_EN
    chk({tag, "_count_cleared"}, int'(spike_count), 0);
`endif
    while (cyc - c0 < 60) begin
      if (cyc - c0 == ghost_at) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk({tag, "_done_pending"}, done_q.size(), 0);
    chk({tag, "_spike_pending"}, spike_q.size(), 0);
    chk({tag, "_busy_end"}, int'(busy), 0);
`ifdef SPIKE_COUNT_EN
    chk({tag, "_count_vs_model"}, int'(spike_count), spk_pred);
    chk({tag, "_count_vs_pulses"}, int'(spike_count), spk_seen);
`endif
    $display("tick %s: start cycle %0d, spikes expected %0d seen %0d", tag, c0, spk_pred, spk_seen);
    done_q.delete();
    spike_q.delete();
  endtask

  // Tick abandoned by reset 10 cycles in, with start raised alongside reset.
  task automatic abort_tick();
    int c0;
    @(posedge clk); #1;
    c0 = cyc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc - c0 < 10) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    reset_model();
    chk("abort_busy", int'(busy), 0);
    repeat (60) @(posedge clk);
    #1;
    chk("abort_no_done_busy", int'(busy), 0);
    $display("tick abort: start cycle %0d, reset at cycle %0d", c0, c0 + 10);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    reset_model();
  endtask

  initial begin
    for (int k = 0; k < NN; k++) cur_i[k] = 0;
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_spike_valid", int'(spike_valid), 0);
    chk("rst_i_addr", int'(i_addr), 0);
`ifdef SPIKE_COUNT_EN
    chk("rst_count", int'(spike_count), 0);
`endif
    check_all("rst");

    // Quiet tick: zero input, unit step.
    tick("quiet", 0);
    check_all("quiet");

    // Second start 5 cycles in must be dropped.
    tick("ghost", 5);
    check_all("ghost");

    // Reset mid-tick, then a normal tick.
    abort_tick();
    check_all("abort");
    tick("post_abort", 0);
    check_all("post_abort");

    // Neuron 3 driven hard from rest fires on the first tick.
    do_reset();
    cur_i[3] = I_FIRE;
    tick("fire1", 0);
    rd_idx = 4'd3;
    #1;
    chk("fire_v3_is_c", sx(rd_v), V_RST);
    chk("fire_w3_hand", sx(rd_w), -1280);   // -13.0 + 0 + 8.0
    check_all("fire1");
    tick("fire2", 0);
    tick("fire3", 0);
    check_all("fire3");

`ifdef SPIKE_COUNT_EN
    do_reset();
    for (int k = 0; k < NN; k++) cur_i[k] = I_FIRE;
    tick("count1", 0);
    tick("count2", 0);
    check_all("count");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
